// File: rtl/jt7759_rom_arb_if.sv
// Bus bundle between the two jt7759 sample fetchers, the ROM arbiter and the
// board ROM controller. The arbiter takes the slave view.
interface jt7759_rom_arb_if #(
  parameter int AW  = 17,
  parameter int RAW = 18
);
    logic           ch0_cs;
    logic [AW-1:0]  ch0_addr;
    logic [7:0]     ch0_dout;
    logic           ch0_ok;
    logic           ch1_cs;
    logic [AW-1:0]  ch1_addr;
    logic [7:0]     ch1_dout;
    logic           ch1_ok;
    logic           rom_cs;
    logic [RAW-1:0] rom_addr;
    logic [7:0]     rom_data;
    logic           rom_ok;

    modport slave (
        input  ch0_cs, ch0_addr, ch1_cs, ch1_addr, rom_data, rom_ok,
        output ch0_dout, ch0_ok, ch1_dout, ch1_ok, rom_cs, rom_addr
    );

    modport master (
        output ch0_cs, ch0_addr, ch1_cs, ch1_addr, rom_data, rom_ok,
        input  ch0_dout, ch0_ok, ch1_dout, ch1_ok, rom_cs, rom_addr
    );
endinterface

// File: rtl/jt7759_rom_arb.sv
// Round-robin sharing of one ROM read port between two uPD7759 sample fetchers.
// Each channel gets its own latched byte and an ok that holds until it withdraws.
module jt7759_rom_arb #(
  parameter int             AW    = 17,
  parameter int             RAW   = 18,
  parameter logic [RAW-1:0] BASE0 = '0,
  parameter logic [RAW-1:0] BASE1 = RAW'(18'h20000)
) (
    input  logic            clk,
    input  logic            rstn,
    jt7759_rom_arb_if.slave bus
);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    state_t         state_q, state_nx;
    logic           gnt_q, last_q, guard_q;
    logic           rom_cs_q;
    logic [RAW-1:0] rom_addr_q;
    logic [AW-1:0]  laddr0_q, laddr1_q;
    logic           valid0_p0, valid1_p0;
    logic           ok0_p1, ok1_p1;
    logic [7:0]     dout0_q, dout1_q;

    logic           pend0, pend1;
    logic           stale0, stale1;
    logic           drop, grant, gsel, abort, latch;

    // ROM offset add; the sum simply wraps at 2^RAW
    function automatic logic [RAW-1:0] rom_map(input logic [RAW-1:0] base,
                                               input logic [AW-1:0]  addr);
        return base + RAW'(addr);
    endfunction

    assign stale0 = !bus.ch0_cs || (bus.ch0_addr != laddr0_q);
    assign stale1 = !bus.ch1_cs || (bus.ch1_addr != laddr1_q);
    assign pend0  = bus.ch0_cs && !valid0_p0;
    assign pend1  = bus.ch1_cs && !valid1_p0;
    assign drop   = gnt_q ? stale1 : stale0;

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        grant    = 1'b0;
        gsel     = 1'b0;
        abort    = 1'b0;
        latch    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend0 || pend1) begin
                    grant    = 1'b1;
                    gsel     = (pend0 && pend1) ? !last_q : pend1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                // withdrawal beats a simultaneous rom_ok; first-cycle ok may be stale
                if (drop) begin
                    abort    = 1'b1;
                    state_nx = GAP;
                end else if (!guard_q && bus.rom_ok) begin
                    latch    = 1'b1;
                    state_nx = GAP;
                end
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            guard_q    <= 1'b0;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            valid0_p0  <= 1'b0;
            valid1_p0  <= 1'b0;
            ok0_p1     <= 1'b0;
            ok1_p1     <= 1'b0;
            dout0_q    <= 8'd0;
            dout1_q    <= 8'd0;
        end else begin
            guard_q <= grant;
            if (grant) begin
                gnt_q      <= gsel;
                last_q     <= gsel;
                rom_cs_q   <= 1'b1;
                rom_addr_q <= gsel ? rom_map(BASE1, bus.ch1_addr)
                                   : rom_map(BASE0, bus.ch0_addr);
            end else if (abort || latch) begin
                rom_cs_q <= 1'b0;
            end

            if (latch && !gnt_q)  dout0_q <= bus.rom_data;
            if (latch &&  gnt_q)  dout1_q <= bus.rom_data;

            if (latch && !gnt_q)  valid0_p0 <= 1'b1;
            else if (stale0)      valid0_p0 <= 1'b0;
            if (latch && gnt_q)   valid1_p0 <= 1'b1;
            else if (stale1)      valid1_p0 <= 1'b0;

            // ok trails valid by one register stage
            ok0_p1 <= valid0_p0;
            ok1_p1 <= valid1_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (grant && !gsel) laddr0_q <= bus.ch0_addr;
        if (grant &&  gsel) laddr1_q <= bus.ch1_addr;
    end

    assign bus.rom_cs   = rom_cs_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.ch0_dout = dout0_q;
    assign bus.ch1_dout = dout1_q;
    assign bus.ch0_ok   = ok0_p1;
    assign bus.ch1_ok   = ok1_p1;

endmodule

// File: tb/tb_jt7759_rom_arb.sv
// Directed bench for jt7759_rom_arb: reset, single fetch, tie round-robin,
// abort, stale rom_ok guard and address wrap (second instance, BASE1=3FFFF).
module tb_jt7759_rom_arb;

    logic clk = 1'b0;
    logic rstn;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    jt7759_rom_arb_if #(.AW(17), .RAW(18)) bus();
    jt7759_rom_arb_if #(.AW(17), .RAW(18)) bw();

    jt7759_rom_arb #(.AW(17), .RAW(18), .BASE0(18'h0), .BASE1(18'h20000)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    jt7759_rom_arb #(.AW(17), .RAW(18), .BASE0(18'h0), .BASE1(18'h3FFFF)) u_wrap (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bw)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // wait for the next ROM strobe, check its address, then wait for it to fall
    task automatic wait_grant(input string tag, input logic [31:0] exp_addr);
        int n;
        n = 0;
        while (!bus.rom_cs && n < 20) begin
            tick();
            n++;
        end
        if (!bus.rom_cs) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else             chk(tag, 32'(bus.rom_addr), exp_addr);
        n = 0;
        while (bus.rom_cs && n < 20) begin
            tick();
            n++;
        end
        if (bus.rom_cs) chk({tag, "_stuck"}, 32'd1, 32'd0);
    endtask

    initial begin
        rstn         = 1'b0;
        bus.ch0_cs   = 1'b1;
        bus.ch0_addr = 17'h00010;
        bus.ch1_cs   = 1'b1;
        bus.ch1_addr = 17'h00004;
        bus.rom_data = 8'h00;
        bus.rom_ok   = 1'b0;
        bw.ch0_cs    = 1'b0;
        bw.ch0_addr  = 17'h0;
        bw.ch1_cs    = 1'b1;
        bw.ch1_addr  = 17'h00002;
        bw.rom_data  = 8'h00;
        bw.rom_ok    = 1'b0;

        // reset with requests held
        tick();
        tick();
        chk("rst_rom_cs", 32'(bus.rom_cs), 32'd0);
        chk("rst_ok0", 32'(bus.ch0_ok), 32'd0);
        chk("rst_ok1", 32'(bus.ch1_ok), 32'd0);
        chk("rst_dout0", 32'(bus.ch0_dout), 32'h00);
        chk("rst_addr", 32'(bus.rom_addr), 32'h0);
        rstn = 1'b1;
        tick();
        chk("first_grant_cs", 32'(bus.rom_cs), 32'd1);
        chk("first_grant_ch0", 32'(bus.rom_addr), 32'h00010);
        chk("wrap_addr", 32'(bw.rom_addr), 32'h00001);

        // reset mid-transfer aborts
        rstn = 1'b0;
        bus.rom_ok = 1'b1;
        tick();
        chk("midrst_rom_cs", 32'(bus.rom_cs), 32'd0);
        bus.ch0_cs = 1'b0;
        bus.ch1_cs = 1'b0;
        bw.ch1_cs  = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        tick();
        chk("midrst_no_ok0", 32'(bus.ch0_ok), 32'd0);
        chk("midrst_dout0", 32'(bus.ch0_dout), 32'h00);

        // single fetch, rom_ok held high
        bus.rom_data = 8'hA5;
        bus.ch0_addr = 17'h00010;
        bus.ch0_cs   = 1'b1;
        tick();
        chk("single_cs", 32'(bus.rom_cs), 32'd1);
        chk("single_addr", 32'(bus.rom_addr), 32'h00010);
        tick();
        chk("single_cs_held", 32'(bus.rom_cs), 32'd1);
        chk("single_ok_early", 32'(bus.ch0_ok), 32'd0);
        tick();
        chk("single_dout", 32'(bus.ch0_dout), 32'hA5);
        chk("single_cs_fall", 32'(bus.rom_cs), 32'd0);
        chk("single_ok_t2", 32'(bus.ch0_ok), 32'd0);
        tick();
        chk("single_ok_t3", 32'(bus.ch0_ok), 32'd1);
        tick();
        tick();
        chk("single_no_refetch", 32'(bus.rom_cs), 32'd0);
        chk("single_ok_hold", 32'(bus.ch0_ok), 32'd1);
        bus.ch0_cs = 1'b0;
        tick();
        chk("single_ok_lag", 32'(bus.ch0_ok), 32'd1);
        tick();
        chk("single_ok_drop", 32'(bus.ch0_ok), 32'd0);
        chk("single_dout_keep", 32'(bus.ch0_dout), 32'hA5);

        // ties alternate 0,1,0,1 starting from reset
        do_reset();
        bus.ch0_addr = 17'h00020;
        bus.ch1_addr = 17'h00004;
        bus.rom_data = 8'h3C;
        bus.ch0_cs   = 1'b1;
        bus.ch1_cs   = 1'b1;
        wait_grant("tie0_addr", 32'h00020);
        chk("tie0_dout", 32'(bus.ch0_dout), 32'h3C);
        bus.rom_data = 8'hC3;
        wait_grant("tie1_addr", 32'h20004);
        chk("tie1_dout", 32'(bus.ch1_dout), 32'hC3);
        tick();
        chk("tie_ok0", 32'(bus.ch0_ok), 32'd1);
        chk("tie_ok1", 32'(bus.ch1_ok), 32'd1);
        bus.ch0_cs = 1'b0;
        bus.ch1_cs = 1'b0;
        tick();
        tick();
        tick();
        chk("tie_ok0_off", 32'(bus.ch0_ok), 32'd0);
        bus.ch0_addr = 17'h00030;
        bus.ch1_addr = 17'h00008;
        bus.rom_data = 8'h4B;
        bus.ch0_cs   = 1'b1;
        bus.ch1_cs   = 1'b1;
        wait_grant("rr0_addr", 32'h00030);
        chk("rr0_dout", 32'(bus.ch0_dout), 32'h4B);
        bus.rom_data = 8'hB2;
        wait_grant("rr1_addr", 32'h20008);
        chk("rr1_dout", 32'(bus.ch1_dout), 32'hB2);

        // abort: ch1 withdraws in its second BUSY cycle while rom_ok is high
        bus.ch0_cs = 1'b0;
        bus.ch1_cs = 1'b0;
        bus.rom_ok = 1'b0;
        tick();
        tick();
        tick();
        bus.ch1_addr = 17'h00005;
        bus.ch1_cs   = 1'b1;
        tick();
        chk("abort_grant1", 32'(bus.rom_addr), 32'h20005);
        bus.ch0_addr = 17'h00040;
        bus.ch0_cs   = 1'b1;
        tick();
        bus.ch1_cs   = 1'b0;
        bus.rom_ok   = 1'b1;
        bus.rom_data = 8'h77;
        tick();
        chk("abort_cs_low", 32'(bus.rom_cs), 32'd0);
        chk("abort_dout1", 32'(bus.ch1_dout), 32'hB2);
        tick();
        chk("abort_gap", 32'(bus.rom_cs), 32'd0);
        chk("abort_ok1", 32'(bus.ch1_ok), 32'd0);
        tick();
        chk("abort_next_cs", 32'(bus.rom_cs), 32'd1);
        chk("abort_next_ch0", 32'(bus.rom_addr), 32'h00040);
        tick();
        tick();
        chk("abort_ch0_dout", 32'(bus.ch0_dout), 32'h77);
        chk("abort_ok1_still", 32'(bus.ch1_ok), 32'd0);

        // stale rom_ok in the first BUSY cycle is ignored
        bus.ch0_cs = 1'b0;
        bus.rom_ok = 1'b0;
        tick();
        tick();
        tick();
        bus.ch0_addr = 17'h00050;
        bus.ch0_cs   = 1'b1;
        tick();
        chk("stale_addr", 32'(bus.rom_addr), 32'h00050);
        bus.rom_ok   = 1'b1;
        bus.rom_data = 8'hEE;
        tick();
        chk("stale_cs_guard", 32'(bus.rom_cs), 32'd1);
        bus.rom_ok   = 1'b0;
        bus.rom_data = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stale_cs_wait", 32'(bus.rom_cs), 32'd1);
        end
        chk("stale_dout_wait", 32'(bus.ch0_dout), 32'h77);
        chk("stale_ok_wait", 32'(bus.ch0_ok), 32'd0);
        bus.rom_ok = 1'b1;
        tick();
        chk("stale_dout", 32'(bus.ch0_dout), 32'h5A);
        chk("stale_cs_fall", 32'(bus.rom_cs), 32'd0);
        tick();
        chk("stale_ok", 32'(bus.ch0_ok), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
